spi_responder: RTL and testbench
================================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops on spi_sclk, spi_ss_n and spi_mosi (legal 2..3).
REQ-002 Parameter IDLE_BYTE, default 8'hFF: byte shifted out when no TX data is available.
REQ-003 clk_clk  in  1  system clock; all logic is on its rising edge.
REQ-004 reset_reset  in  1  asynchronous, active-high reset.
REQ-005 spi_sclk  in  1  SPI clock from the master, asynchronous to clk_clk.
REQ-006 spi_ss_n  in  1  active-low slave select, asynchronous.
REQ-007 spi_mosi  in  1  master-out data, asynchronous.
REQ-008 spi_miso  out  1  slave-out data.
REQ-009 spi_miso_oe  out  1  MISO drive enable; high only while selected.
REQ-010 tx_data  in  8  next byte to transmit.
REQ-011 tx_valid  in  1  tx_data valid.
REQ-012 tx_ready  out  1  responder accepts tx_data this cycle.
REQ-013 rx_data  out  8  last received byte; held until the next byte completes.
REQ-014 rx_valid  out  1  one-cycle pulse, rx_data updated.
REQ-015 underrun  out  1  one-cycle pulse, IDLE_BYTE substituted.
REQ-016 abort  out  1  one-cycle pulse, frame ended mid-byte.
REQ-017 busy  out  1  high while in ACTIVE.

Function
REQ-018 SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit bytes; spi_sclk frequency SHALL be at most clk_clk/8.
REQ-019 Edges are detected on the synchronized signals; the rising and falling edges of sclk_s and ss_n_s are each detected exactly once.
REQ-020 FSM states: IDLE, ACTIVE. IDLE->ACTIVE on ss_n_s falling; ACTIVE->IDLE on ss_n_s rising.
REQ-021 On entry to ACTIVE: bit counter = 0, a TX byte is loaded into the shift register, and spi_miso = its bit 7 in the same cycle.
REQ-022 On sclk_s rising in ACTIVE: shift mosi_s into the RX shift register LSB and increment the 3-bit counter.
REQ-023 On the 8th rising edge (counter wraps 7->0): rx_data <= assembled byte and rx_valid pulses in the next cycle.
REQ-024 On sclk_s falling in ACTIVE: if counter != 0, shift the TX register left; if counter == 0 (byte boundary), load the next TX byte.
REQ-025 TX load takes the holding register if it is full, otherwise IDLE_BYTE with an underrun pulse in that cycle.
REQ-026 The holding register is one byte; tx_ready = holding empty; the handshake is tx_valid && tx_ready; a load and an accept in the same cycle are legal (the load empties, then the accept refills).
REQ-027 ss_n_s rising with counter != 0: discard the partial RX byte, no rx_valid, abort pulse; the holding register is retained.
REQ-028 spi_miso_oe = busy; spi_miso = 0 when not busy.
REQ-029 sclk edges in IDLE are ignored.

Reset
REQ-030 Reset SHALL force: state IDLE; counter 0; shift registers 0; holding empty; tx_ready=1; rx_data=8'h00; spi_miso=0, spi_miso_oe=0; rx_valid, underrun, abort, busy = 0.
REQ-031 Synchronizer flops SHALL reset to sclk=0, ss_n=1, mosi=0, so that no false edge is detected on release.
REQ-032 Reset mid-frame SHALL abandon the frame without an abort pulse; after reset is released, the responder waits for a fresh ss_n falling edge.

Configuration
REQ-033 Macro SPI_RESPONDER_TXFIFO_EN: when defined, a 4-entry TX FIFO replaces the holding register; tx_ready = FIFO not full; load pops the head; underrun only when the FIFO is empty.
REQ-034 When SPI_RESPONDER_TXFIFO_EN is undefined, the single holding register of REQ-026 applies.

Structure
REQ-035 Package chesssoc_spi_pkg SHALL hold the state enum (IDLE, ACTIVE), the byte width constant (8) and the default IDLE_BYTE.
REQ-036 Sub-module spi_resp_txfifo (depth parameter, valid/ready in, pop/empty out) is used only under SPI_RESPONDER_TXFIFO_EN.

Verification
REQ-037 Preload 8'hA5, master sends 8'h3C at clk/16 -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with one rx_valid pulse.
REQ-038 Two-byte frame with only 8'h11 loaded -> second byte reads 8'hFF, one underrun pulse at the second byte's boundary.
REQ-039 ss_n raised after 5 bits -> abort pulse, no rx_valid, rx_data unchanged, busy=0.
REQ-040 tx_valid held high with 8'h5A at the exact load cycle -> load and accept occur in the same cycle; the next byte sent is 8'h5A with no underrun.
REQ-041 reset_reset asserted mid-byte -> all outputs at reset values next cycle; after release, sclk toggles with ss_n high -> no activity.
REQ-042 With SPI_RESPONDER_TXFIFO_EN: push 8'h01..8'h04 -> tx_ready low after the 4th push; 4-byte frame reads 01,02,03,04; 5th byte reads 8'hFF with underrun.

Source files
------------

// File: rtl/chesssoc_spi_pkg.sv
// Shared types and constants for the SPI responder slice.
`timescale 1ns/1ps
package chesssoc_spi_pkg;

    localparam int         BYTE_W            = 8;
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_resp_txfifo.sv
// Small TX byte FIFO feeding the SPI responder shift register.
`timescale 1ns/1ps
module spi_resp_txfifo
    import chesssoc_spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              push_valid,
    input  logic [BYTE_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop,
    output logic [BYTE_W-1:0] pop_data,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign empty      = (count == '0);
    assign push_ready = (count != (AW+1)'(DEPTH));
    assign pop_data   = mem[rd_ptr];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_responder.sv
// Mode-0 SPI responder with synchronized inputs and a TX holding stage.
// Build option SPI_RESPONDER_TXFIFO_EN swaps the holding register for a 4-entry FIFO.
//
// state  | meaning
// IDLE   | not selected, MISO released, sclk ignored
// ACTIVE | selected, shifting bytes on sclk edges
`timescale 1ns/1ps
module spi_responder
    import chesssoc_spi_pkg::*;
#(
    parameter int              SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun,
    output logic              abort,
    output logic              busy
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   ss_n_s;
    logic                   mosi_s;
    logic                   sclk_d;
    logic                   ss_n_d;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ss_fall;
    logic                   ss_rise;

    spi_state_e        state;
    spi_state_e        state_next;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] tx_shift;
    logic [BYTE_W-1:0] rx_shift;
    logic              tx_load;
    logic              do_rx;
    logic              do_tx_shift;
    logic              frame_end;

    logic [BYTE_W-1:0] hold_data;
    logic              hold_empty;

    // Reset values chosen so that release never looks like an edge.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_n_d    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            ss_n_d    <= ss_n_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_n_s    = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_n_s & ss_n_d;
    assign ss_rise   = ss_n_s & ~ss_n_d;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Deselect wins over a coincident sclk edge, so the master's trailing
    // clock fall does not consume a TX byte when ss_n rises with it.
    always_comb begin
        state_next  = state;
        tx_load     = 1'b0;
        do_rx       = 1'b0;
        do_tx_shift = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = ACTIVE;
                    tx_load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    do_rx = sclk_rise;
                    if (sclk_fall) begin
                        tx_load     = (bit_cnt == 3'd0);
                        do_tx_shift = (bit_cnt != 3'd0);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            bit_cnt  <= 3'd0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;

            if (tx_load) begin
                tx_shift <= hold_empty ? IDLE_BYTE : hold_data;
                underrun <= hold_empty;
            end else if (do_tx_shift) begin
                tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            end

            if (state == IDLE && ss_fall) begin
                bit_cnt <= 3'd0;
            end else if (do_rx) begin
                rx_shift <= {rx_shift[BYTE_W-2:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {rx_shift[BYTE_W-2:0], mosi_s};
                    rx_valid <= 1'b1;
                end
            end else if (frame_end) begin
                bit_cnt  <= 3'd0;
                rx_shift <= '0;
                abort    <= (bit_cnt != 3'd0);
            end
        end
    end

`ifdef SPI_RESPONDER_TXFIFO_EN
    spi_resp_txfifo #(
        .DEPTH (4)
    ) u_txfifo (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .push_valid  (tx_valid),
        .push_data   (tx_data),
        .push_ready  (tx_ready),
        .pop         (tx_load),
        .pop_data    (hold_data),
        .empty       (hold_empty)
    );
`else
    logic hold_full;

    // A load frees the slot in the same cycle, so an accept can refill it.
    assign tx_ready   = ~hold_full | tx_load;
    assign hold_empty = ~hold_full;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_valid && tx_ready) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (tx_load) begin
            hold_full <= 1'b0;
        end
    end
`endif

    assign busy        = (state == ACTIVE);
    assign spi_miso_oe = busy;
    assign spi_miso    = busy & tx_shift[BYTE_W-1];

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: table vectors, directed corner cases, random frames.
`timescale 1ns/1ps
module tb_spi_responder;

    localparam int HALF = 80;
`ifdef SPI_RESPONDER_TXFIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       spi_sclk, spi_ss_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, underrun, abort, busy;

    spi_responder dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .spi_sclk    (spi_sclk),
        .spi_ss_n    (spi_ss_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .underrun    (underrun),
        .abort       (abort),
        .busy        (busy)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int n_rxv = 0, n_ur = 0, n_ab = 0;
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (rx_valid) n_rxv++;
            if (underrun) n_ur++;
            if (abort)    n_ab++;
        end
    end

    // Reference model: bytes waiting for transmission, last received byte.
    logic [7:0] q[$];
    logic [7:0] exp_rx = 8'h00;
    logic [7:0] m_tx[8];
    logic [7:0] m_rx[8];

    task automatic push(input logic [7:0] d);
        @(negedge clk_clk);
        tx_data  = d;
        tx_valid = 1'b1;
        check("tx_ready_on_push", tx_ready, (q.size() < CAP));
        if (q.size() < CAP) q.push_back(d);
        @(negedge clk_clk);
        tx_valid = 1'b0;
    endtask

    // Frame of nb bytes; ab_bits>0 ends the last byte after that many bits.
    task automatic run_frame(input int nb, input int ab_bits);
        logic [7:0] e[8];
        int eur, r0, u0, a0, full, bits;
        eur = 0;
        for (int b = 0; b < nb; b++) begin
            if (q.size() > 0) e[b] = q.pop_front();
            else begin e[b] = 8'hFF; eur++; end
        end
        r0 = n_rxv; u0 = n_ur; a0 = n_ab;
        @(negedge clk_clk);
        spi_ss_n = 1'b0;
        #(2*HALF);
        for (int b = 0; b < nb; b++) begin
            bits = (ab_bits > 0 && b == nb - 1) ? ab_bits : 8;
            m_rx[b] = 8'h00;
            for (int i = 0; i < bits; i++) begin
                spi_mosi = m_tx[b][7-i];
                #HALF;
                spi_sclk = 1'b1;
                m_rx[b][7-i] = spi_miso;
                #HALF;
                spi_sclk = 1'b0;
                if (ab_bits == 0 && b == nb - 1 && i == 7) spi_ss_n = 1'b1;
            end
        end
        if (ab_bits > 0) begin
            #HALF;
            spi_ss_n = 1'b1;
        end
        spi_mosi = 1'b0;
        repeat (8) @(negedge clk_clk);
        full = (ab_bits > 0) ? nb - 1 : nb;
        for (int b = 0; b < nb; b++) begin
            bits = (ab_bits > 0 && b == nb - 1) ? ab_bits : 8;
            check("miso_byte", m_rx[b] >> (8 - bits), e[b] >> (8 - bits));
        end
        if (full > 0) exp_rx = m_tx[full-1];
        check("rx_valid_count", n_rxv - r0, full);
        check("rx_data", rx_data, exp_rx);
        check("underrun_count", n_ur - u0, eur);
        check("abort_count", n_ab - a0, (ab_bits > 0));
        check("busy_after_frame", busy, 0);
        check("miso_oe_after_frame", spi_miso_oe, 0);
    endtask

    typedef struct {
        bit         has_pre;
        logic [7:0] pre;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_ur;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, a0, r0, got;
        logic [7:0] prev;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
        vecs[2] = '{1'b0, 8'h00, 8'h81, 8'hFF, 8'h81, 1};
        vecs[3] = '{1'b1, 8'hC3, 8'h00, 8'hC3, 8'h00, 0};

        reset_reset = 1'b1;
        spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (4) @(negedge clk_clk);
        check("rst_busy", busy, 0);
        check("rst_miso_oe", spi_miso_oe, 0);
        check("rst_miso", spi_miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_pulses", {rx_valid, underrun, abort}, 3'b000);
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);
        check("post_rst_idle", busy, 0);

        for (int v = 0; v < 4; v++) begin
            u0 = n_ur;
            if (vecs[v].has_pre) push(vecs[v].pre);
            m_tx[0] = vecs[v].mosi;
            run_frame(1, 0);
            check("tbl_miso", m_rx[0], vecs[v].exp_miso);
            check("tbl_rx", rx_data, vecs[v].exp_rx);
            check("tbl_underrun", n_ur - u0, vecs[v].exp_ur);
        end

        // Two-byte frame with a single byte queued.
        u0 = n_ur;
        push(8'h11);
        m_tx[0] = 8'h27; m_tx[1] = 8'hE4;
        run_frame(2, 0);
        check("two_byte_b0", m_rx[0], 8'h11);
        check("two_byte_b1", m_rx[1], 8'hFF);
        check("two_byte_underrun", n_ur - u0, 1);

        // Deselect after 5 bits.
        prev = rx_data; a0 = n_ab; r0 = n_rxv;
        push(8'h66);
        m_tx[0] = 8'h9B;
        run_frame(1, 5);
        check("abort_rx_held", rx_data, prev);
        check("abort_pulse", n_ab - a0, 1);
        check("abort_no_rxv", n_rxv - r0, 0);
        check("abort_busy", busy, 0);

        // Accept held off until a boundary load, then accepted in that cycle.
        push(8'h3C);
        q.push_back(8'hB7);
        q.push_back(8'h5A);
        for (int b = 0; b < 3; b++) m_tx[b] = 8'($urandom);
        u0 = n_ur; got = 0;
        fork
            run_frame(3, 0);
            begin
                repeat (12) @(negedge clk_clk);
                tx_data = 8'hB7; tx_valid = 1'b1;
                @(negedge clk_clk);
                tx_valid = 1'b0;
                @(negedge clk_clk);
                tx_data = 8'h5A; tx_valid = 1'b1;
                if (CAP == 1) check("held_not_ready", tx_ready, 0);
                for (int c = 0; c < 600 && got == 0; c++) begin
                    @(negedge clk_clk);
                    if (tx_ready) begin
                        got = 1;
                        check("accept_during_frame", busy, 1);
                        @(negedge clk_clk);
                    end
                end
                tx_valid = 1'b0;
            end
        join
        check("held_accepted", got, 1);
        check("held_no_underrun", n_ur - u0, 0);
        check("held_third_byte", m_rx[2], 8'h5A);

`ifdef SPI_RESPONDER_TXFIFO_EN
        for (int k = 1; k <= 4; k++) push(8'(k));
        @(negedge clk_clk);
        check("fifo_full_ready", tx_ready, 0);
        u0 = n_ur;
        for (int b = 0; b < 5; b++) m_tx[b] = 8'($urandom);
        run_frame(5, 0);
        for (int b = 0; b < 4; b++) check("fifo_byte", m_rx[b], 8'(b + 1));
        check("fifo_5th", m_rx[4], 8'hFF);
        check("fifo_underrun", n_ur - u0, 1);
`endif

        for (int f = 0; f < 10; f++) begin
            int np, nb, ab;
            np = $urandom_range(0, CAP + 1);
            for (int p = 0; p < np; p++) push(8'($urandom));
            nb = $urandom_range(1, 3);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int b = 0; b < nb; b++) m_tx[b] = 8'($urandom);
            run_frame(nb, ab);
        end

        // Reset in the middle of a byte.
        push(8'hD2);
        a0 = n_ab;
        @(negedge clk_clk);
        spi_ss_n = 1'b0;
        #(2*HALF);
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1; #HALF; spi_sclk = 1'b1; #HALF; spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk_clk);
        check("pre_reset_busy", busy, 1);
        reset_reset = 1'b1;
        @(posedge clk_clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_miso", {spi_miso, spi_miso_oe}, 2'b00);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_pulses", {rx_valid, underrun, abort}, 3'b000);
        check("midrst_tx_ready", tx_ready, 1);
        spi_ss_n = 1'b1;
        q.delete();
        exp_rx = 8'h00;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        u0 = n_ur; r0 = n_rxv;
        for (int i = 0; i < 8; i++) begin
            spi_mosi = 1'($urandom); #HALF; spi_sclk = 1'b1; #HALF; spi_sclk = 1'b0;
        end
        repeat (8) @(negedge clk_clk);
        check("idle_sclk_busy", busy, 0);
        check("idle_sclk_rxv", n_rxv - r0, 0);
        check("idle_sclk_ur", n_ur - u0, 0);
        check("reset_no_abort", n_ab - a0, 0);
        check("idle_sclk_rx", rx_data, 8'h00);
        check("idle_tx_ready", tx_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
